// File: rtl/uart_main.sv
// 8N1 UART: one TX frame per send_trigger rising edge, LED toggle per valid RX byte.
// Optional feature: define UART_ECHO_EN to retransmit every valid received byte.
module uart_main #(
  parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
  parameter int unsigned BAUD         = 115_200,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD
) (
  input  logic       user_clock,
  input  logic       rst,
  input  logic       usb_rs232_rxd,
  input  logic       send_trigger,
  input  logic [7:0] send_data,
  output logic       usb_rs232_txd,
  output logic       gpio_led1
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  logic          trig_q, trig_prev, trig_rise;
  logic          rx_s1, rx_s2;
  state_t        tx_state, tx_state_n, rx_state, rx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n, rx_cnt, rx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n, rx_bit, rx_bit_n;
  logic [7:0]    tx_data, tx_data_n;
  logic          rx_hold, rx_hold_n, rx_valid;
  logic          txd_d, led_d;
`ifdef UART_ECHO_EN
  logic          echo_valid, echo_valid_n, echo_take;
  logic [7:0]    echo_data, echo_data_n, rx_shift, rx_shift_n;
`endif

  assign trig_rise = trig_q & ~trig_prev;

  // State and datapath registers
  always_ff @(posedge user_clock or posedge rst) begin
    if (rst) begin
      trig_q        <= 1'b0;
      trig_prev     <= 1'b0;
      rx_s1         <= 1'b1;
      rx_s2         <= 1'b1;
      tx_state      <= ST_IDLE;
      tx_cnt        <= '0;
      tx_bit        <= '0;
      tx_data       <= '0;
      rx_state      <= ST_IDLE;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_hold       <= 1'b0;
      usb_rs232_txd <= 1'b1;
      gpio_led1     <= 1'b0;
`ifdef UART_ECHO_EN
      echo_valid    <= 1'b0;
      echo_data     <= '0;
      rx_shift      <= '0;
`endif
    end else begin
      trig_q        <= send_trigger;
      trig_prev     <= trig_q;
      rx_s1         <= usb_rs232_rxd;
      rx_s2         <= rx_s1;
      tx_state      <= tx_state_n;
      tx_cnt        <= tx_cnt_n;
      tx_bit        <= tx_bit_n;
      tx_data       <= tx_data_n;
      rx_state      <= rx_state_n;
      rx_cnt        <= rx_cnt_n;
      rx_bit        <= rx_bit_n;
      rx_hold       <= rx_hold_n;
      usb_rs232_txd <= txd_d;
      gpio_led1     <= led_d;
`ifdef UART_ECHO_EN
      echo_valid    <= echo_valid_n;
      echo_data     <= echo_data_n;
      rx_shift      <= rx_shift_n;
`endif
    end
  end

  // Next-state logic for both FSMs
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + CW'(1);
    tx_bit_n   = tx_bit;
    tx_data_n  = tx_data;
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + CW'(1);
    rx_bit_n   = rx_bit;
    rx_hold_n  = rx_hold & ~rx_s2;
    rx_valid   = 1'b0;
`ifdef UART_ECHO_EN
    echo_take  = 1'b0;
    rx_shift_n = rx_shift;
`endif

    unique case (tx_state)
      ST_IDLE: begin
        tx_cnt_n = '0;
        if (trig_rise) begin
          tx_state_n = ST_START;
          tx_data_n  = send_data;
        end
`ifdef UART_ECHO_EN
        else if (echo_valid) begin
          tx_state_n = ST_START;
          tx_data_n  = echo_data;
          echo_take  = 1'b1;
        end
`endif
      end
      ST_START: if (tx_cnt == BIT_LAST) begin
        tx_state_n = ST_DATA;
        tx_cnt_n   = '0;
        tx_bit_n   = '0;
      end
      ST_DATA: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n = '0;
        if (tx_bit == 3'd7) tx_state_n = ST_STOP;
        else                tx_bit_n   = tx_bit + 3'd1;
      end
      default: if (tx_cnt == BIT_LAST) begin
        tx_state_n = ST_IDLE;
        tx_cnt_n   = '0;
      end
    endcase

    // A line left low by a framing error must be seen high before re-arming
    unique case (rx_state)
      ST_IDLE: begin
        rx_cnt_n = '0;
        if (!rx_s2 && !rx_hold) rx_state_n = ST_START;
      end
      ST_START: if (rx_cnt == HALF_LAST) begin
        rx_cnt_n   = '0;
        rx_bit_n   = '0;
        rx_state_n = rx_s2 ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (rx_cnt == BIT_LAST) begin
        rx_cnt_n = '0;
`ifdef UART_ECHO_EN
        rx_shift_n = {rx_s2, rx_shift[7:1]};
`endif
        if (rx_bit == 3'd7) rx_state_n = ST_STOP;
        else                rx_bit_n   = rx_bit + 3'd1;
      end
      default: if (rx_cnt == BIT_LAST) begin
        rx_cnt_n   = '0;
        rx_state_n = ST_IDLE;
        if (rx_s2) rx_valid  = 1'b1;
        else       rx_hold_n = 1'b1;
      end
    endcase

`ifdef UART_ECHO_EN
    echo_valid_n = echo_valid & ~echo_take;
    echo_data_n  = echo_data;
    if (rx_valid) begin
      echo_valid_n = 1'b1;
      echo_data_n  = rx_shift;
    end
`endif
  end

  // Registered-output values derived from the upcoming state
  always_comb begin
    txd_d = 1'b1;
    led_d = gpio_led1 ^ rx_valid;
    unique case (tx_state_n)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = tx_data_n[tx_bit_n];
      default:  txd_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_main.sv
// Self-checking bench for uart_main: frame-level model of TX and RX at the default 434 clocks/bit.
`timescale 1ns/1ps
module tb_uart_main;

  localparam int unsigned CPB     = 434;
  localparam int          CHK_OLD = 9 * CPB + CPB / 2 - 15;
  localparam int          CHK_NEW = 9 * CPB + CPB / 2 + 20;

  logic       user_clock = 1'b0;
  logic       rst = 1'b1;
  logic       usb_rs232_rxd = 1'b1;
  logic       send_trigger = 1'b0;
  logic [7:0] send_data = 8'h00;
  logic       usb_rs232_txd, gpio_led1;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic led_exp = 1'b0;

  always #10 user_clock = ~user_clock;

  uart_main dut (
    .user_clock    (user_clock),
    .rst           (rst),
    .usb_rs232_rxd (usb_rs232_rxd),
    .send_trigger  (send_trigger),
    .send_data     (send_data),
    .usb_rs232_txd (usb_rs232_txd),
    .gpio_led1     (gpio_led1)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge user_clock);
    #1;
  endtask

  // Line level of bit b of an 8N1 frame carrying d
  function automatic logic frame_bit(input logic [7:0] d, input int b, input logic stop);
    if (b == 0) return 1'b0;
    if (b == 9) return stop;
    return d[b-1];
  endfunction

  // Called on the first clock of the start bit; checks both ends of every bit
  task automatic tx_frame_check(input logic [7:0] d);
    for (int b = 0; b < 10; b++) begin
      check("tx_bit_first", usb_rs232_txd, frame_bit(d, b, 1'b1));
      repeat (CPB - 1) tick();
      check("tx_bit_last", usb_rs232_txd, frame_bit(d, b, 1'b1));
      tick();
    end
    check("tx_idle_after", usb_rs232_txd, 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_data    = d;
    send_trigger = 1'b1;
    tick();
    check("tx_pre_start", usb_rs232_txd, 1'b1);
    send_trigger = 1'b0;
    tick();
    send_data = ~d;
    tx_frame_check(d);
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop);
    for (int t = 0; t < 10 * int'(CPB); t++) begin
      usb_rs232_rxd = frame_bit(d, t / int'(CPB), stop);
      if (t == CHK_OLD) check("rx_led_before_stop", gpio_led1, led_exp);
      if (t == CHK_NEW) begin
        led_exp ^= stop;
        check("rx_led_after_stop", gpio_led1, led_exp);
`ifndef UART_ECHO_EN
        check("rx_no_tx_activity", usb_rs232_txd, 1'b1);
`endif
      end
      tick();
    end
    usb_rs232_rxd = 1'b1;
  endtask

  task automatic rx_idle(input int n);
    usb_rs232_rxd = 1'b1;
    repeat (n) tick();
  endtask

`ifdef UART_ECHO_EN
  task automatic echo_expect(input logic [7:0] d);
    int n = 0;
    while (usb_rs232_txd && n < 6000) begin
      tick();
      n++;
    end
    check("echo_start", usb_rs232_txd, 1'b0);
    if (!usb_rs232_txd) tx_frame_check(d);
  endtask
`endif

  initial begin
    #1_900_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       bad;
    logic       stop;

    repeat (3) @(posedge user_clock);
    #1;
    check("rst_txd", usb_rs232_txd, 1'b1);
    check("rst_led", gpio_led1, 1'b0);
    rst = 1'b0;
    repeat (500) tick();
    check("idle_txd", usb_rs232_txd, 1'b1);
    check("idle_led", gpio_led1, 1'b0);

    send_byte(8'h51);
    repeat (10) tick();

    // Held trigger plus a second edge while busy: one frame only
    send_data    = 8'hA5;
    send_trigger = 1'b1;
    tick();
    check("held_pre_start", usb_rs232_txd, 1'b1);
    fork
      begin
        repeat (39) tick();
        send_trigger = 1'b0;
        repeat (960) tick();
        send_data    = 8'h00;
        send_trigger = 1'b1;
        tick();
        send_trigger = 1'b0;
      end
    join_none
    tick();
    tx_frame_check(8'hA5);
    bad = 1'b0;
    repeat (3 * CPB) begin
      tick();
      if (!usb_rs232_txd) bad = 1'b1;
    end
    check("tx_no_second_frame", bad, 1'b0);

    // Reset during data bit 3 (a zero bit of 8'h37)
    send_data    = 8'h37;
    send_trigger = 1'b1;
    tick();
    send_trigger = 1'b0;
    tick();
    repeat (4 * CPB + CPB / 2) tick();
    check("tx_bit3_before_rst", usb_rs232_txd, 1'b0);
    rst = 1'b1;
    #1;
    check("tx_rst_async", usb_rs232_txd, 1'b1);
    check("led_rst_async", gpio_led1, 1'b0);
    repeat (5) tick();
    rst = 1'b0;
    repeat (20) tick();
    check("tx_idle_after_rst", usb_rs232_txd, 1'b1);
    send_byte(8'hC3);

    for (int i = 0; i < 2; i++) begin
      d = 8'($urandom);
      repeat ($urandom_range(1, 50)) tick();
      send_byte(d);
    end

`ifdef UART_ECHO_EN
    fork
      rx_frame(8'h58, 1'b1);
      echo_expect(8'h58);
    join
    rx_idle(CPB);
`endif

    // Two back-to-back valid frames
    rx_frame(8'h41, 1'b1);
    rx_frame(8'h41, 1'b1);
    rx_idle(CPB);

    rx_frame(8'h5A, 1'b0);
    rx_idle(CPB);
    check("rx_framing_err_led", gpio_led1, led_exp);

    usb_rs232_rxd = 1'b0;
    repeat (100) tick();
    rx_idle(1000);
    check("rx_glitch_led", gpio_led1, led_exp);

    rx_frame(8'h33, 1'b1);
    rx_idle(CPB);

    for (int i = 0; i < 3; i++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      rx_frame(d, stop);
      rx_idle(CPB);
    end
    check("rx_final_led", gpio_led1, led_exp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
